// File: rtl/pb_pkg.sv
// Shared types for the push-button gesture classifier: FSM states and the
// event bundle handed to application FSMs.
package pb_pkg;

  typedef enum logic [2:0] {IDLE, PRESS1, LONG, GAP, PRESS2} pb_cls_state_t;

  typedef struct packed {
    logic single_ev;
    logic double_ev;
    logic long_ev;
    logic repeat_ev;
  } pb_events_t;

  function automatic int pb_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pb_press_classifier.sv
// Classifies debounced press/release pulses into single click, double click
// and long press, with an auto-repeat tick while a long press is held.
//
// state  | meaning
// IDLE   | button up, no gesture in progress
// PRESS1 | first press held, timing toward long press
// LONG   | long press held, emitting repeat ticks
// GAP    | short press released, waiting for a second press
// PRESS2 | second press held, waiting for its release
module pb_press_classifier
  import pb_pkg::*;
#(
  parameter int LONG_CYCLES       = 50_000_000,
  parameter int DCLICK_GAP_CYCLES = 25_000_000,
  parameter int REPEAT_CYCLES     = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_pressed_pulse,
  input  logic pb_released_pulse,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_tick,
  output logic busy
);

  localparam int TW = $clog2(pb_max3(LONG_CYCLES, DCLICK_GAP_CYCLES, REPEAT_CYCLES));
  localparam logic [TW-1:0] LONG_TC = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] GAP_TC  = TW'(DCLICK_GAP_CYCLES - 1);
  localparam logic [TW-1:0] REP_TC  = TW'(REPEAT_CYCLES - 1);

  pb_cls_state_t state_q;
  logic [TW-1:0] timer_q;
  pb_events_t    ev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      ev_q    <= '0;
    end else begin
      ev_q    <= '0;
      timer_q <= timer_q + 1'b1;
      unique case (state_q)
        // No threshold in IDLE or PRESS2, so the timer is parked at zero there.
        IDLE: begin
          timer_q <= '0;
          if (pb_pressed_pulse) state_q <= PRESS1;
        end
        PRESS1: begin
          if (pb_released_pulse) begin
            state_q <= GAP;
            timer_q <= '0;
          end else if (timer_q == LONG_TC) begin
            state_q      <= LONG;
            timer_q      <= '0;
            ev_q.long_ev <= 1'b1;
          end
        end
        LONG: begin
          if (pb_released_pulse) begin
            state_q <= IDLE;
            timer_q <= '0;
          end else if (timer_q == REP_TC) begin
            timer_q        <= '0;
            ev_q.repeat_ev <= 1'b1;
          end
        end
        GAP: begin
          if (pb_pressed_pulse) begin
            state_q        <= PRESS2;
            timer_q        <= '0;
            ev_q.double_ev <= 1'b1;
          end else if (timer_q == GAP_TC) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            ev_q.single_ev <= 1'b1;
          end
        end
        PRESS2: begin
          timer_q <= '0;
          if (pb_released_pulse) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign single_click = ev_q.single_ev;
  assign double_click = ev_q.double_ev;
  assign long_press   = ev_q.long_ev;
  assign repeat_tick  = ev_q.repeat_ev;
  assign busy         = (state_q != IDLE);

endmodule
